// File: rtl/bram_pkg.sv
// bram_pkg: shared BRAM geometry defaults and copy-engine state encoding.
package bram_pkg;
  localparam int BRAM_WIDTH = 16;
  localparam int BRAM_DEPTH = 1024;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} copy_state_t;
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/bram_copy_addr_gen.sv
// bram_copy_addr_gen: loadable up/down word address counter with remaining-count output.
module bram_copy_addr_gen
  import bram_pkg::*;
#(
  parameter int AW = addr_w(BRAM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic          i_step,
  input  logic          i_down,
  input  logic [AW-1:0] i_addr,
  input  logic [AW:0]   i_cnt,
  output logic [AW-1:0] o_addr,
  output logic [AW:0]   o_rem
);
  logic [AW-1:0] r_addr;
  logic [AW:0]   r_rem;
  logic          r_down;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_rem  <= '0;
      r_down <= 1'b0;
    end else if (i_load) begin
      r_addr <= i_addr;
      r_rem  <= i_cnt;
      r_down <= i_down;
    end else if (i_step) begin
      r_addr <= r_down ? r_addr - 1'b1 : r_addr + 1'b1;
      r_rem  <= r_rem - 1'b1;
    end
  end
  assign o_addr = r_addr;
  assign o_rem  = r_rem;
endmodule

// File: rtl/bram_copy_engine.sv
// bram_copy_engine: copies a word block inside one dual-port BRAM, reading port A
// and writing port B one cycle behind, choosing direction so overlaps copy safely.
module bram_copy_engine
  import bram_pkg::*;
#(
  parameter int WIDTH = BRAM_WIDTH,
  parameter int DEPTH = BRAM_DEPTH,
  localparam int AW = addr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AW-1:0]    src_addr,
  input  logic [AW-1:0]    dst_addr,
  input  logic [AW:0]      len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             read_en_a,
  output logic [AW-1:0]    addr_a,
  input  logic [WIDTH-1:0] data_out_a,
  output logic             write_en_b,
  output logic [AW-1:0]    addr_b,
  output logic [WIDTH-1:0] data_in_b
);
  localparam logic [AW+1:0] DEPTH_X = (AW+2)'(DEPTH);
  localparam logic [AW:0]   ONE     = (AW+1)'(1);
  copy_state_t   r_state, w_next;
  logic          r_wr_vld, r_err;
  logic [AW+1:0] w_src_end, w_dst_end;
  logic          w_bad, w_down, w_accept, w_load;
  logic [AW-1:0] w_ofs, w_rd_start, w_wr_start, w_rd_addr, w_wr_addr;
  logic [AW:0]   w_rd_rem, w_wr_rem;
  assign w_src_end  = {2'b00, src_addr} + {1'b0, len};
  assign w_dst_end  = {2'b00, dst_addr} + {1'b0, len};
  assign w_bad      = (w_src_end > DEPTH_X) || (w_dst_end > DEPTH_X);
  // Destination starting inside the source block would clobber unread words going up.
  assign w_down     = (dst_addr > src_addr) && ({2'b00, dst_addr} < w_src_end);
  assign w_accept   = start && (r_state == IDLE || r_state == DONE);
  assign w_load     = w_accept && !w_bad && (len != '0);
  assign w_ofs      = AW'(len) - 1'b1;
  assign w_rd_start = w_down ? src_addr + w_ofs : src_addr;
  assign w_wr_start = w_down ? dst_addr + w_ofs : dst_addr;
  bram_copy_addr_gen #(.AW(AW)) u_rd_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_step (r_state == RUN),
    .i_down (w_down),
    .i_addr (w_rd_start),
    .i_cnt  (len),
    .o_addr (w_rd_addr),
    .o_rem  (w_rd_rem)
  );
  bram_copy_addr_gen #(.AW(AW)) u_wr_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_step (r_wr_vld),
    .i_down (w_down),
    .i_addr (w_wr_start),
    .i_cnt  (len),
    .o_addr (w_wr_addr),
    .o_rem  (w_wr_rem)
  );
  always_comb begin
    w_next = r_state;
    if (w_accept)
      w_next = w_bad ? IDLE : (len == '0) ? DONE : RUN;
    else if (r_state == DONE)
      w_next = IDLE;
    else if (r_state == RUN && w_rd_rem == ONE)
      w_next = DRAIN;
    else if (r_state == DRAIN && w_wr_rem == ONE)
      w_next = DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_wr_vld <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_wr_vld <= (r_state == RUN);
      r_err    <= w_accept && w_bad;
    end
  end
  assign busy       = (r_state == RUN) || (r_state == DRAIN);
  assign done       = (r_state == DONE);
  assign err        = r_err;
  assign read_en_a  = (r_state == RUN);
  assign addr_a     = w_rd_addr;
  assign write_en_b = r_wr_vld;
  assign addr_b     = w_wr_addr;
  assign data_in_b  = r_wr_vld ? data_out_a : '0;
endmodule

// File: tb/tb_bram_copy_engine.sv
// tb_bram_copy_engine: randomized copy requests against a memmove-style reference
// model, with an attached registered-read memory checked by back-door compare.
module tb_bram_copy_engine;
  localparam int W  = 16;
  localparam int D  = 1024;
  localparam int AW = 10;
  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [AW-1:0] src_addr = '0, dst_addr = '0;
  logic [AW:0]   len = '0;
  logic          busy, done, err, read_en_a, write_en_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [W-1:0]  data_out_a, data_in_b;
  logic [W-1:0]  mem [D];
  logic [W-1:0]  ref_mem [D];
  logic [W-1:0]  init_pat [D];
  logic          fill = 1'b0, bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [W-1:0]  bd_data = '0;
  int            n_chk = 0, n_pass = 0;
  bram_copy_engine #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .read_en_a  (read_en_a),
    .addr_a     (addr_a),
    .data_out_a (data_out_a),
    .write_en_b (write_en_b),
    .addr_b     (addr_b),
    .data_in_b  (data_in_b)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (fill) for (int i = 0; i < D; i++) mem[i] <= init_pat[i];
    if (bd_we) mem[bd_addr] <= bd_data;
    if (read_en_a) data_out_a <= mem[addr_a];
    if (write_en_b) mem[addr_b] <= data_in_b;
  end
  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic mem_chk(input string tag);
    int diffs = 0;
    for (int i = 0; i < D; i++) if (mem[i] !== ref_mem[i]) diffs++;
    chk({tag, ".mem"}, diffs, 0);
  endtask
  task automatic poke(input int a, input int v);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a[AW-1:0]; bd_data = v[W-1:0];
    ref_mem[a] = v[W-1:0];
    @(negedge clk);
    bd_we = 1'b0;
  endtask
  task automatic req(input int s, input int d, input int n);
    start = 1'b1; src_addr = s[AW-1:0]; dst_addr = d[AW-1:0]; len = n[AW:0];
  endtask
  // Request must already be driven; observes the transfer from E0 onwards.
  task automatic run(input string nm, input int s, input int d, input int n,
                     input bit hold, input bit chain, input int ns, input int nd, input int nn);
    bit bad, down;
    int exp_done, lim, j, ea;
    int n_rd = 0, n_wr = 0, n_busy = 0, n_done = 0, n_err = 0, done_cyc = 0, rd_bad = 0, wr_bad = 0;
    logic [W-1:0] snap [$];
    bad  = (s + n > D) || (d + n > D);
    down = (d > s) && (d < s + n);
    if (!bad) begin
      for (int i = 0; i < n; i++) snap.push_back(ref_mem[s + i]);
      for (int i = 0; i < n; i++) ref_mem[d + i] = snap[i];
    end
    exp_done = bad ? 0 : (n == 0) ? 1 : n + 2;
    lim = (bad ? 2 : exp_done) + (chain ? 0 : 1);
    @(posedge clk); #1;
    start = hold; src_addr = AW'($urandom); dst_addr = AW'($urandom); len = (AW+1)'($urandom);
    for (int k = 1; k <= lim; k++) begin
      @(negedge clk);
      if (read_en_a) begin
        ea = down ? s + n - 1 - n_rd : s + n_rd;
        if (addr_a !== AW'(ea)) rd_bad++;
        n_rd++;
      end
      if (write_en_b) begin
        if (n_wr < n) begin
          j = down ? n - 1 - n_wr : n_wr;
          if (addr_b !== AW'(d + j) || data_in_b !== snap[j]) wr_bad++;
        end else wr_bad++;
        n_wr++;
      end
      n_busy += int'(busy);
      n_err  += int'(err);
      if (done) begin
        n_done++;
        if (done_cyc == 0) done_cyc = k;
      end
      if (chain && k == lim) req(ns, nd, nn);
      else if (hold && k <= n + 1) begin
        src_addr = AW'($urandom); dst_addr = AW'($urandom); len = (AW+1)'($urandom);
      end else start = 1'b0;
    end
    chk({nm, ".rd_cnt"}, n_rd, bad ? 0 : n);
    chk({nm, ".wr_cnt"}, n_wr, bad ? 0 : n);
    chk({nm, ".busy_cyc"}, n_busy, (bad || n == 0) ? 0 : n + 1);
    chk({nm, ".done_cyc"}, done_cyc, exp_done);
    chk({nm, ".done_cnt"}, n_done, bad ? 0 : 1);
    chk({nm, ".err_cnt"}, n_err, bad ? 1 : 0);
    chk({nm, ".rd_addr"}, rd_bad, 0);
    chk({nm, ".wr_seq"}, wr_bad, 0);
    mem_chk(nm);
  endtask
  task automatic go(input string nm, input int s, input int d, input int n, input bit hold);
    @(negedge clk);
    req(s, d, n);
    run(nm, s, d, n, hold, 1'b0, 0, 0, 0);
  endtask
  initial begin
    int s, d, n, nd0;
    bit hold;
    for (int i = 0; i < D; i++) begin
      init_pat[i] = W'($urandom);
      ref_mem[i]  = init_pat[i];
    end
    @(negedge clk); fill = 1'b1;
    @(negedge clk); fill = 1'b0;
    #2;
    chk("reset.outs", {busy, done, err, read_en_a, write_en_b, addr_a, addr_b, data_in_b}, 0);
    @(negedge clk); rst_n = 1'b1;
    poke(10, 'hABCD); poke(11, 'h1234); poke(12, 'h5555); poke(13, 'hAAAA);
    go("asc", 10, 20, 4, 1'b0);
    chk("asc.word23", mem[23], 'hAAAA);
    for (int i = 0; i < 8; i++) poke(i, i);
    go("ovl", 0, 2, 6, 1'b0);
    chk("ovl.word7", mem[7], 5);
    chk("ovl.word1", mem[1], 1);
    go("bnd_ok", 1020, 0, 4, 1'b0);
    go("bnd_err", 1021, 0, 4, 1'b0);
    go("dst_err", 0, 1022, 3, 1'b0);
    go("len0", 50, 60, 0, 1'b0);
    @(negedge clk);
    req(200, 210, 4);
    run("hold", 200, 210, 4, 1'b1, 1'b1, 300, 301, 2);
    run("chain", 300, 301, 2, 1'b0, 1'b0, 0, 0, 0);
    @(negedge clk);
    req(100, 300, 8);
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.pre_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1 chk("rst.async_outs", {busy, done, err, read_en_a, write_en_b, addr_a, addr_b, data_in_b}, 0);
    ref_mem[300] = ref_mem[100];
    n = 0;
    repeat (3) begin
      @(negedge clk);
      n += int'(done);
    end
    chk("rst.no_done", n, 0);
    rst_n = 1'b1;
    mem_chk("rst");
    go("post_rst", 100, 300, 8, 1'b0);
    go("max", 0, 0, 1024, 1'b0);
    for (int t = 0; t < 24; t++) begin
      s = ($urandom_range(0, 3) == 0) ? D - int'($urandom_range(1, 40)) : int'($urandom_range(0, D - 1));
      n = $urandom_range(0, 40);
      nd0 = ($urandom_range(0, 2) == 0) ? s + int'($urandom_range(0, n)) : int'($urandom_range(0, D - 1));
      d = nd0 % D;
      hold = (s + n <= D) && (d + n <= D) && (n > 0) && ($urandom_range(0, 1) == 1);
      go($sformatf("rnd%0d", t), s, d, n, hold);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/bram_copy_engine.md
Name: bram_copy_engine

Overview:
- Initiator-side controller for the team's true dual-port BRAM (`bram`, WIDTH x DEPTH, registered read with one-cycle latency).
- Copies a block of `len` words from `src_addr` to `dst_addr` inside one BRAM instance, at one word per clock.
- Drives port A as the read port and port B as the write port.
- Sits between a control/CPU-style requester and the `bram` instance, replacing hand-driven port stimulus.

Parameters:
- WIDTH, 16, data word width; must match the `bram` WIDTH.
- DEPTH, 1024, number of words; must match the `bram` DEPTH. AW = $clog2(DEPTH).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only when the engine is IDLE.
- src_addr  in  AW  first source word address.
- dst_addr  in  AW  first destination word address.
- len  in  AW+1  word count, 0..DEPTH.
- busy  out  1  high while a transfer is in progress.
- done  out  1  one-cycle pulse when a transfer completes.
- err  out  1  one-cycle pulse when a request is rejected.
- read_en_a  out  1  BRAM port A read enable.
- addr_a  out  AW  BRAM port A address.
- data_out_a  in  WIDTH  BRAM port A read data, valid one cycle after read_en_a.
- write_en_b  out  1  BRAM port B write enable.
- addr_b  out  AW  BRAM port B address.
- data_in_b  out  WIDTH  BRAM port B write data.

Behaviour:
- Reset: rst_n low asynchronously forces state IDLE and clears every output to 0 (busy, done, err, read_en_a, write_en_b, addr_a, addr_b, data_in_b) and all counters.
- Reset mid-transfer abandons the copy; there is no done pulse. Words already written stay written.
- Request capture (IDLE with start=1 at edge E0): src_addr, dst_addr and len are latched; later changes on these inputs are ignored until the engine returns to IDLE.
- Request validation, checked in the E0 cycle with AW+2-bit arithmetic:
  - src+len > DEPTH or dst+len > DEPTH -> err pulse in the cycle after E0; no BRAM access; stay in IDLE.
  - len == 0 -> done pulse in the cycle after E0; no access; busy stays 0.
- Direction:
  - If dst > src and dst < src+len (overlapping, forward-destructive), copy descending: addresses run from src+len-1 / dst+len-1 down to src / dst.
  - Otherwise copy ascending.
  - src == dst copies in place, ascending.
- Timing for a valid request with len = N:
  - read_en_a is high for exactly N consecutive cycles, starting the cycle after E0; addr_a steps by ±1 each cycle.
  - write_en_b is high for exactly N consecutive cycles, starting one cycle after the first read.
  - data_in_b = data_out_a combinationally from the registered BRAM output; addr_b is a one-cycle-delayed copy of addr_a.
  - busy is high from the cycle after E0 through the last write cycle (N+1 cycles).
  - done pulses in the cycle immediately after the last write. IDLE is re-entered in that same cycle, so start is accepted there.
- Throughput: 1 word/clk. Total latency from start to done is N+2 clocks.
- State machine:
  - IDLE -> RUN on a valid request with len > 0.
  - RUN (reads issued, writes trailing) -> DRAIN after the Nth read.
  - DRAIN performs the final write -> DONE.
  - DONE pulses done -> IDLE.
- Counters:
  - rd_cnt counts down from N.
  - A one-bit write-valid pipeline register tracks read latency.
  - Address arithmetic wraps modulo DEPTH internally; the validation step guarantees no wrap is ever presented to the BRAM.
- start while busy is ignored; there is no queue.
- Port A is never written and port B is never read by this block.

Decomposition:
- Package bram_pkg holds:
  - state enum type copy_state_t {IDLE, RUN, DRAIN, DONE};
  - default WIDTH/DEPTH localparams, shared with `bram` and its bench;
  - function addr_w(depth) returning $clog2(depth).
- One natural sub-module, bram_copy_addr_gen: loadable up/down address counter with a remaining-count output, instantiated twice (read side and write side).
- The bench instantiates `bram` together with bram_copy_engine and checks memory contents by back-door read.

Test Plan:
- Ascending copy: preload words 10..13 = ABCD, 1234, 5555, AAAA; start src=10, dst=20, len=4 -> words 20..23 hold the same four values; busy high 5 cycles; done pulses at E0+6; read_en_a high 4 cycles.
- Overlapping descending copy: words 0..7 = 0..7; src=0, dst=2, len=6 -> words 2..7 = 0..5; words 0,1 unchanged; addr_a sequence 5,4,3,2,1,0.
- Boundary and errors:
  - src=1020, len=4 at DEPTH=1024 -> succeeds; last addr_a = 1023.
  - src=1021, len=4 -> err pulse, no read_en_a/write_en_b activity.
  - len=0 -> done only.
- start held high and re-pulsed during busy -> ignored. A new start in the done cycle is accepted and a second copy of len=2 completes correctly.
- Reset mid-transfer: rst_n low 3 cycles into a len=8 copy -> all outputs 0 immediately (asynchronous, not waiting for the clock edge); no done; the next request after release copies correctly.
- Back-to-back maximum: src=0, dst=0, len=1024 -> 1024 contiguous writes, done at E0+1026, memory unchanged.
